// File: rtl/status_bar_ctrl_if.sv
// Event inputs and display-facing outputs of the HUD status-bar controller.
// The game logic drives the events as master; the controller is the slave.
interface status_bar_ctrl_if;
  logic       clk_1hz;
  logic       frame_start;
  logic       game_start;
  logic       hero_hit;
  logic       level_clear;
  logic       bar_enable;
  logic [9:0] gauge_r;
  logic [2:0] lives;
  logic       blink_on;
  logic       game_over;
  logic [6:0] power;

  modport master (
    output clk_1hz, frame_start, game_start, hero_hit, level_clear,
    input  bar_enable, gauge_r, lives, blink_on, game_over, power
  );

  modport slave (
    input  clk_1hz, frame_start, game_start, hero_hit, level_clear,
    output bar_enable, gauge_r, lives, blink_on, game_over, power
  );
endinterface

// File: rtl/status_bar_ctrl.sv
// Hero power gauge, lives counter and game-phase FSM for the HUD status bar.
// Display-facing outputs are shadow registers refreshed only on frame_start.
module status_bar_ctrl #(
  parameter int unsigned POWER_MAX   = 100,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned LOW_THRESH  = 20,
  parameter int unsigned HIT_COST    = 10,
  parameter int unsigned DEAD_SECS   = 2,
  parameter int unsigned BAR_L       = 0,
  parameter int unsigned PX_PER_UNIT = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  status_bar_ctrl_if.slave         bus
);

  localparam int unsigned DCW = (DEAD_SECS > 1) ? $clog2(DEAD_SECS) : 1;
  localparam logic [6:0]     P_MAX     = 7'(POWER_MAX);
  localparam logic [6:0]     P_LOW     = 7'(LOW_THRESH);
  localparam logic [7:0]     P_HIT     = 8'(HIT_COST);
  localparam logic [2:0]     L_INIT    = 3'(LIVES_INIT);
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_SECS - 1);
  localparam logic [9:0]     G_FULL    = 10'(BAR_L + PX_PER_UNIT * POWER_MAX);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LOW, S_DEAD, S_OVER} state_t;

  state_t         state_q, state_d;
  logic [6:0]     power_q, power_d;
  logic [2:0]     lives_q, lives_d;
  logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
  logic           blink_q, blink_d;
  logic           game_over_q;
  logic           clk1_q;

  logic           bar_en_sh_q;
  logic [9:0]     gauge_sh_q;
  logic [2:0]     lives_sh_q;
  logic           blink_sh_q;

  logic           tick;
  logic [7:0]     dec;
  logic [6:0]     power_sub;
  logic [9:0]     gauge_now;

  assign tick      = bus.clk_1hz & ~clk1_q;
  assign dec       = (bus.hero_hit ? P_HIT : 8'd0) + {7'd0, tick};
  assign power_sub = ({1'b0, power_q} > dec) ? 7'({1'b0, power_q} - dec) : '0;
  assign gauge_now = 10'(BAR_L + PX_PER_UNIT * 32'(power_q));

  always_comb begin
    state_d    = state_q;
    power_d    = power_q;
    lives_d    = lives_q;
    dead_cnt_d = dead_cnt_q;
    blink_d    = blink_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.game_start) begin
          state_d = S_RUN;
          power_d = P_MAX;
          lives_d = L_INIT;
          blink_d = 1'b1;
        end
      end
      S_RUN, S_LOW: begin
        // level_clear wins over any same-cycle hit/tick; game_start is ignored here
        if (bus.level_clear) begin
          state_d = S_RUN;
          power_d = P_MAX;
          blink_d = 1'b1;
        end else begin
          power_d = power_sub;
          if (power_sub == '0) begin
            state_d    = S_DEAD;
            lives_d    = (lives_q == '0) ? '0 : lives_q - 3'd1;
            dead_cnt_d = '0;
            blink_d    = 1'b0;
          end else if (power_sub <= P_LOW) begin
            state_d = S_LOW;
            if (state_q == S_LOW && tick) blink_d = ~blink_q;
          end else begin
            state_d = S_RUN;
            blink_d = 1'b1;
          end
        end
      end
      S_DEAD: begin
        blink_d = 1'b0;
        if (tick) begin
          if (dead_cnt_q == DEAD_LAST) begin
            if (lives_q == '0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_RUN;
              power_d = P_MAX;
              blink_d = 1'b1;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (bus.game_start) begin
          state_d = S_RUN;
          power_d = P_MAX;
          lives_d = L_INIT;
          blink_d = 1'b1;
        end else if (tick) begin
          blink_d = ~blink_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      power_q     <= P_MAX;
      lives_q     <= L_INIT;
      dead_cnt_q  <= '0;
      blink_q     <= 1'b1;
      game_over_q <= 1'b0;
      clk1_q      <= bus.clk_1hz;
      bar_en_sh_q <= 1'b0;
      gauge_sh_q  <= G_FULL;
      lives_sh_q  <= L_INIT;
      blink_sh_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      power_q     <= power_d;
      lives_q     <= lives_d;
      dead_cnt_q  <= dead_cnt_d;
      blink_q     <= blink_d;
      game_over_q <= (state_d == S_OVER);
      clk1_q      <= bus.clk_1hz;
      // shadows take the pre-update values so same-cycle events show next frame
      if (bus.frame_start) begin
        bar_en_sh_q <= (state_q != S_IDLE);
        gauge_sh_q  <= gauge_now;
        lives_sh_q  <= lives_q;
        blink_sh_q  <= blink_q;
      end
    end
  end

  assign bus.bar_enable = bar_en_sh_q;
  assign bus.gauge_r    = gauge_sh_q;
  assign bus.lives      = lives_sh_q;
  assign bus.blink_on   = blink_sh_q;
  assign bus.game_over  = game_over_q;
  assign bus.power      = power_q;

endmodule
